// File: rtl/sample_readout.sv
// Streams pre-trigger-aligned samples from the 4-channel circular sample RAM to the TX FIFO.
// Define SAMPLE_READOUT_HEADER_EN to prefix each readout with a 4-byte header.
module sample_readout #(
    parameter int RAM_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 data_ready,
    input  logic                 start_read,
    input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
    input  logic [RAM_WIDTH-1:0] triggerpoint,
    input  logic [RAM_WIDTH-1:0] nsmp,
    input  logic [3:0]           chanmask,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    input  logic [7:0]           ram_q1,
    input  logic [7:0]           ram_q2,
    input  logic [7:0]           ram_q3,
    input  logic [7:0]           ram_q4,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_ADDR, S_WAIT, S_SEND, S_DONE} state_t;

    state_t               r_state;
    logic [RAM_WIDTH-1:0] r_base;
    logic [RAM_WIDTH-1:0] r_nsmp;
    logic [RAM_WIDTH-1:0] r_idx;
    logic [3:0]           r_mask;
    logic [1:0]           r_ch;
    logic                 r_rden;
    logic [RAM_WIDTH-1:0] r_rdaddress;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_aborted;
`ifdef SAMPLE_READOUT_HEADER_EN
    logic [1:0]           r_hdr_cnt;
    logic [15:0]          w_nsmp16;
    logic [7:0]           w_hdr_next;
`endif

    logic [RAM_WIDTH-1:0] w_base;
    logic [RAM_WIDTH-1:0] w_idx_inc;
    logic                 w_ch_end;
    logic [3:0]           w_above;
    logic [1:0]           w_ch_nx;
    logic                 w_last_ch;
    logic                 w_accept;
    logic                 w_empty_in;
    logic [7:0]           w_ram_q;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        logic       found;
        logic [1:0] res;
        found = 1'b0;
        res   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (m[i] && !found) begin
                res   = 2'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_base     = wraddress_triggerpoint - triggerpoint;
    assign w_idx_inc  = r_idx + 1'b1;
    assign w_ch_end   = (w_idx_inc == r_nsmp);
    // Channels strictly above the current one: clear bits 0..r_ch of the latched mask.
    assign w_above    = r_mask & ~(4'((5'd2 << r_ch) - 5'd1));
    assign w_ch_nx    = f_lowest(w_above);
    assign w_last_ch  = (w_above == '0);
    assign w_accept   = r_tx_valid && tx_ready;
    assign w_empty_in = (chanmask == '0) || (nsmp == '0);

    always_comb begin
        w_ram_q = ram_q1;
        case (r_ch)
            2'd1:    w_ram_q = ram_q2;
            2'd2:    w_ram_q = ram_q3;
            2'd3:    w_ram_q = ram_q4;
            default: w_ram_q = ram_q1;
        endcase
    end

`ifdef SAMPLE_READOUT_HEADER_EN
    assign w_nsmp16 = 16'(r_nsmp);
    always_comb begin
        w_hdr_next = w_nsmp16[7:0];
        case (r_hdr_cnt)
            2'd0:    w_hdr_next = {4'b0, r_mask};
            2'd1:    w_hdr_next = w_nsmp16[15:8];
            default: w_hdr_next = w_nsmp16[7:0];
        endcase
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_nsmp      <= '0;
            r_idx       <= '0;
            r_mask      <= '0;
            r_ch        <= '0;
            r_rden      <= 1'b0;
            r_rdaddress <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
`ifdef SAMPLE_READOUT_HEADER_EN
            r_hdr_cnt   <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_read && data_ready) begin
                        r_base <= w_base;
                        r_nsmp <= nsmp;
                        r_mask <= chanmask;
                        r_ch   <= f_lowest(chanmask);
                        r_idx  <= '0;
                        r_busy <= 1'b1;
`ifdef SAMPLE_READOUT_HEADER_EN
                        r_hdr_cnt  <= '0;
                        r_tx_data  <= 8'hA5;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_HDR;
`else
                        if (w_empty_in) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_rden      <= 1'b1;
                            r_rdaddress <= w_base;
                            r_state     <= S_ADDR;
                        end
`endif
                    end
                end
`ifdef SAMPLE_READOUT_HEADER_EN
                S_HDR: begin
                    if (w_accept) begin
                        if (!data_ready) begin
                            r_tx_valid <= 1'b0;
                            r_aborted  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end else if (r_hdr_cnt == 2'd3) begin
                            r_tx_valid <= 1'b0;
                            if (r_mask == '0 || r_nsmp == '0) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_rden      <= 1'b1;
                                r_rdaddress <= r_base;
                                r_state     <= S_ADDR;
                            end
                        end else begin
                            r_hdr_cnt <= r_hdr_cnt + 1'b1;
                            r_tx_data <= w_hdr_next;
                        end
                    end
                end
`endif
                S_ADDR: begin
                    r_rden <= 1'b0;
                    if (!data_ready) begin
                        r_aborted <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_tx_data  <= w_ram_q;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_tx_valid <= 1'b0;
                        if (!data_ready) begin
                            r_aborted <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end else if (w_ch_end) begin
                            r_idx <= '0;
                            r_ch  <= w_ch_nx;
                            if (w_last_ch) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                r_rden      <= 1'b1;
                                r_rdaddress <= r_base;
                                r_state     <= S_ADDR;
                            end
                        end else begin
                            r_idx       <= w_idx_inc;
                            r_rden      <= 1'b1;
                            r_rdaddress <= r_base + w_idx_inc;
                            r_state     <= S_ADDR;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rden      = r_rden;
    assign rdaddress = r_rdaddress;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule
